// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - az_cpu pipeline stall/flush control, exception handling and control registers
module pipe_ctrl #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [1:0]  EXRT_OP      = 2'h2,
  parameter logic [1:0]  WRCR_OP      = 2'h1,
  parameter logic [1:0]  HALT_OP      = 2'h3
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        irq,
  input  logic [29:0] mem_pc,
  input  logic        mem_en,
  input  logic        mem_br_flag,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_dst_addr,
  input  logic [2:0]  mem_exp_code,
  input  logic [31:0] mem_out,
  input  logic [1:0]  creg_rd_addr,
  output logic [31:0] creg_rd_data,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc,
  output logic        exe_mode,
  output logic        int_en,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic        exe_mode_q, int_en_q, pre_exe_mode_q, pre_int_en_q;
  logic [29:0] epc_q, exp_vector_q, halt_pc_q;
  logic [2:0]  exp_code_q;
  logic        wake_q;

  logic        stall_all, mem_go, wake_go, exc_go, exrt_go, halt_go, wrcr_go;
  logic [2:0]  exc_code;
  logic [29:0] exc_epc;
  logic        unused_ok;

  assign unused_ok = ^mem_dst_addr[4:2];

  always_comb begin
    state_d   = state_q;
    stall_all = if_busy | mem_busy | (state_q == HALT);
    // the wake-up interrupt owns the first RUN cycle, so MEM is ignored then
    mem_go    = mem_en & ~stall_all & ~wake_q;
    wake_go   = wake_q & ~stall_all;
    exc_go    = wake_go | (mem_go & ((mem_exp_code != 3'd0) | (irq & int_en_q)));
    exrt_go   = mem_go & ~exc_go & (mem_ctrl_op == EXRT_OP);
    halt_go   = mem_go & ~exc_go & (mem_ctrl_op == HALT_OP);
    wrcr_go   = mem_go & ~exc_go & (mem_ctrl_op == WRCR_OP) & exe_mode_q;
    exc_code  = (wake_go || mem_exp_code == 3'd0) ? 3'd1 : mem_exp_code;
    exc_epc   = wake_go ? halt_pc_q : (mem_br_flag ? mem_pc - 30'd1 : mem_pc);

    {if_stall, id_stall, ex_stall, mem_stall} = 4'b0000;
    {if_flush, id_flush, ex_flush, mem_flush} = 4'b0000;
    if (stall_all) begin
      {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
    end else if (exc_go || exrt_go) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
    end else if (halt_go) begin
      {if_flush, id_flush, ex_flush} = 3'b111;
    end else if (ld_hazard) begin
      {if_stall, id_stall, id_flush} = 3'b111;
    end

    new_pc = exc_go ? exp_vector_q : (exrt_go ? epc_q : 30'd0);

    case (state_q)
      RUN:     if (halt_go) state_d = HALT;
      HALT:    if (irq && int_en_q) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    case (creg_rd_addr)
      2'd0:    creg_rd_data = {28'd0, pre_int_en_q, pre_exe_mode_q, int_en_q, exe_mode_q};
      2'd1:    creg_rd_data = {epc_q, 2'b00};
      2'd2:    creg_rd_data = {exp_vector_q, 2'b00};
      default: creg_rd_data = {29'd0, exp_code_q};
    endcase
    if (wrcr_go && mem_dst_addr[1:0] == creg_rd_addr) creg_rd_data = mem_out;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q        <= RUN;
      exe_mode_q     <= 1'b1;
      int_en_q       <= 1'b0;
      pre_exe_mode_q <= 1'b0;
      pre_int_en_q   <= 1'b0;
      epc_q          <= 30'd0;
      exp_vector_q   <= RESET_VECTOR;
      exp_code_q     <= 3'd0;
      halt_pc_q      <= 30'd0;
      wake_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (halt_go) halt_pc_q <= mem_pc + 30'd1;
      if (state_q == HALT && state_d == RUN) wake_q <= 1'b1;
      else if (wake_go)                      wake_q <= 1'b0;

      if (exc_go) begin
        epc_q          <= exc_epc;
        pre_exe_mode_q <= exe_mode_q;
        pre_int_en_q   <= int_en_q;
        exe_mode_q     <= 1'b1;
        int_en_q       <= 1'b0;
        exp_code_q     <= exc_code;
      end else if (exrt_go) begin
        exe_mode_q <= pre_exe_mode_q;
        int_en_q   <= pre_int_en_q;
      end else if (wrcr_go) begin
        case (mem_dst_addr[1:0])
          2'd0:    {pre_int_en_q, pre_exe_mode_q, int_en_q, exe_mode_q} <= mem_out[3:0];
          2'd1:    epc_q        <= mem_out[31:2];
          2'd2:    exp_vector_q <= mem_out[31:2];
          default: exp_code_q   <= mem_out[2:0];
        endcase
      end
    end
  end

  assign exe_mode = exe_mode_q;
  assign int_en   = int_en_q;
  assign halted   = (state_q == HALT);

endmodule
